onn_phase_scan_ctrl: RTL and testbench
======================================

Name: onn_phase_scan_ctrl

Overview:
- Scheduler that time-shares one phase-difference measurement datapath across all N oscillator neurons of the ONN array.
- On `start`, walks target index 0..N-1 and measures, in clock cycles, the lag from a rising edge of the latched reference oscillator to the next rising edge of each target.
- Streams one result per target over a valid/ready interface to the readout/weight-update logic, then pulses `done`.

Parameters:
- N_OSC, 8, number of oscillator inputs (≥2)
- IDX_W, $clog2(N_OSC), index width
- CNT_W, 16, phase counter / result width
- SETTLE_CYC, 4, idle cycles after selecting a target before arming (mux/edge-detector settle)
- TIMEOUT, 4096, max cycles per measurement (WAIT_REF + COUNT combined); must be < 2^(CNT_W-1)

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-high reset
- start, in, 1, one-cycle scan request; ignored while busy=1
- ref_sel, in, IDX_W, reference oscillator index; latched on accepted start
- osc_in, in, N_OSC, oscillator outputs, already synchronous to clk
- busy, out, 1, high from the cycle after an accepted start until done
- res_valid, out, 1, result available
- res_ready, in, 1, consumer accepts the result
- res_idx, out, IDX_W, target index of the current result
- res_phase, out, signed CNT_W, measured lag in cycles (≥0)
- res_timeout, out, 1, measurement aborted by TIMEOUT
- done, out, 1, one-cycle pulse after the last result is accepted

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, FSM=IDLE, idx=0, counters 0, prev_osc=0.
- Reset mid-scan: everything aborts immediately; no partial result is held.
- Edge detect: prev_osc registers osc_in every cycle, in every state. Rise[k] = osc_in[k] & ~prev_osc[k] (combinational).
- States: IDLE, SETTLE, WAIT_REF, COUNT, REPORT, FINISH.
- IDLE:
  - start=1 → latch ref_sel as ref, idx<=0, scnt<=0, busy<=1, go to SETTLE.
  - ref_sel ≥ N_OSC → ref forced to 0.
- SETTLE: scnt increments each cycle. When scnt==SETTLE_CYC-1: tcnt<=0, go to WAIT_REF.
- WAIT_REF:
  - idx==ref → phase=0, timeout=0, go to REPORT (no wait).
  - rise[ref] & rise[idx] in the same cycle → phase=0, go to REPORT.
  - rise[ref] only → cnt<=1, go to COUNT.
- COUNT:
  - rise[idx] → phase=cnt, go to REPORT. Phase is the cycle distance from the reference edge to the target edge.
  - Otherwise cnt<=cnt+1.
  - Further reference edges in COUNT are ignored.
- Timeout: tcnt increments every cycle in WAIT_REF and COUNT. At tcnt==TIMEOUT-1 with no completing edge: phase=0, timeout=1, go to REPORT.
- REPORT:
  - res_valid=1 with res_idx/res_phase/res_timeout stable until the res_valid & res_ready cycle.
  - Transfer then: res_valid<=0 next cycle.
  - If idx==N_OSC-1 go to FINISH; else idx<=idx+1, scnt<=0, go to SETTLE.
- FINISH: done=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency: with SETTLE_CYC=4 and res_ready tied high, result k appears ≥ 4+1 cycles after entering SETTLE.
- Results are emitted strictly in idx order, no drops. Backpressure stalls the scan indefinitely with no timeout in REPORT.
- A start coincident with done, or arriving while busy, is ignored.

Decomposition:
- Shared package onn_pkg: state enum (phase_scan_state_t), CNT_W default, and result struct {idx, phase, timeout}.
- One natural sub-module: onn_edge_det (N-bit registered rising-edge detector), reusable by the other neuron control blocks.

Test Plan:
- N_OSC=4, ref=0, osc1 rises 5 cycles after osc0, osc2 at 0 cycles, osc3 at 12 cycles, res_ready=1 → results (0,0,0), (1,5,0), (2,0,0), (3,12,0), then done pulse, busy=0.
- Target osc2 held low, TIMEOUT=64 → result idx2 arrives exactly 64 cycles after WAIT_REF entry with timeout=1, phase=0; scan continues to idx3.
- res_ready low for 20 cycles during result idx1 → res_valid/res_idx/res_phase stable for all 20 cycles; SETTLE for idx2 starts the cycle after the handshake.
- start asserted again while busy, and ref_sel=9 with N_OSC=4 → second start ignored; out-of-range ref scans with ref=0.
- reset pulsed while in COUNT for idx2 → all outputs 0 same cycle; a new start yields a full clean scan from idx0.
- Reference rises twice before the target (period 10, target lag 15) → phase=15 (extra reference edges ignored).

Source files
------------

// File: rtl/onn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onn_pkg
//  Description : Shared types for the ONN neuron control blocks: phase-scan
//                FSM state encoding, default counter width and the result
//                record handed to the readout / weight-update logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package onn_pkg;

    // Default phase counter / result width
    localparam int ONN_CNT_W = 16;
    // Index width of the shared result record (covers arrays up to 256 neurons)
    localparam int ONN_IDX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_REF = 3'd2,
        ST_COUNT    = 3'd3,
        ST_REPORT   = 3'd4,
        ST_FINISH   = 3'd5
    } phase_scan_state_t;

    typedef struct packed {
        logic [ONN_IDX_W-1:0]        idx;
        logic signed [ONN_CNT_W-1:0] phase;
        logic                        timeout;
    } phase_result_t;

endpackage
`default_nettype wire

// File: rtl/onn_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : onn_edge_det
//  Description : W-bit registered rising-edge detector. The previous sample is
//                registered every cycle; rise is combinational from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module onn_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sig_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    // Next previous-sample value is simply the current input
    always_comb begin
        prev_d = sig_in;
    end

    // Previous-sample register, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/onn_phase_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : onn_phase_scan_ctrl
//  Description : Time-shares one phase-difference measurement over all
//                oscillator neurons. For each target index it measures the
//                lag (in cycles) from a reference rising edge to the next
//                target rising edge and streams results over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module onn_phase_scan_ctrl
    import onn_pkg::*;
#(
    parameter int N_OSC      = 8,
    parameter int IDX_W      = $clog2(N_OSC),
    parameter int CNT_W      = ONN_CNT_W,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IDX_W-1:0]        ref_sel,
    input  logic [N_OSC-1:0]        osc_in,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDX_W-1:0]        res_idx,
    output logic signed [CNT_W-1:0] res_phase,
    output logic                    res_timeout,
    output logic                    done
);

    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT);

    localparam logic [SCNT_W-1:0] c_settle_last = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [TCNT_W-1:0] c_tcnt_last   = TCNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  c_idx_last    = IDX_W'(N_OSC - 1);

    logic [N_OSC-1:0]        w_rise;
    logic                    w_ref_rise;
    logic                    w_tgt_rise;

    phase_scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]        ref_q, ref_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SCNT_W-1:0]       scnt_q, scnt_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    res_valid_q, res_valid_d;
    logic [IDX_W-1:0]        res_idx_q, res_idx_d;
    logic signed [CNT_W-1:0] res_phase_q, res_phase_d;
    logic                    res_timeout_q, res_timeout_d;

    logic                    meas_done;
    logic                    meas_to;
    logic [CNT_W-1:0]        meas_phase;

    onn_edge_det #(
        .W (N_OSC)
    ) u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .sig_in (osc_in),
        .rise   (w_rise)
    );

    // Pick the rising-edge flags of the latched reference and current target
    always_comb begin
        w_ref_rise = 1'b0;
        w_tgt_rise = 1'b0;
        for (int k = 0; k < N_OSC; k++) begin
            if (ref_q == IDX_W'(k)) w_ref_rise = w_rise[k];
            if (idx_q == IDX_W'(k)) w_tgt_rise = w_rise[k];
        end
    end

    // Scan sequencing, measurement counters and result capture
    always_comb begin
        state_d       = state_q;
        ref_d         = ref_q;
        idx_d         = idx_q;
        scnt_d        = scnt_q;
        tcnt_d        = tcnt_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        res_valid_d   = res_valid_q;
        res_idx_d     = res_idx_q;
        res_phase_d   = res_phase_q;
        res_timeout_d = res_timeout_q;
        done          = 1'b0;
        meas_done     = 1'b0;
        meas_to       = 1'b0;
        meas_phase    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Out-of-range reference falls back to oscillator 0
                    ref_d   = (int'(ref_sel) < N_OSC) ? ref_sel : '0;
                    idx_d   = '0;
                    scnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                scnt_d = scnt_q + 1'b1;
                if (scnt_q == c_settle_last) begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT_REF;
                end
            end
            ST_WAIT_REF: begin
                tcnt_d = tcnt_q + 1'b1;
                if (idx_q == ref_q) begin
                    meas_done = 1'b1;
                end else if (w_ref_rise && w_tgt_rise) begin
                    meas_done = 1'b1;
                end else if (tcnt_q == c_tcnt_last) begin
                    meas_done = 1'b1;
                    meas_to   = 1'b1;
                end else if (w_ref_rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Additional reference edges are deliberately ignored here
                tcnt_d = tcnt_q + 1'b1;
                if (w_tgt_rise) begin
                    meas_done  = 1'b1;
                    meas_phase = cnt_q;
                end else if (tcnt_q == c_tcnt_last) begin
                    meas_done = 1'b1;
                    meas_to   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REPORT: begin
                // Result stays frozen until accepted; no timeout here
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == c_idx_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        scnt_d  = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (meas_done) begin
            res_valid_d   = 1'b1;
            res_idx_d     = idx_q;
            res_phase_d   = $signed(meas_phase);
            res_timeout_d = meas_to;
            state_d       = ST_REPORT;
        end
    end

    // State and datapath registers; reset aborts any scan in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ref_q         <= '0;
            idx_q         <= '0;
            scnt_q        <= '0;
            tcnt_q        <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_phase_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_q         <= ref_d;
            idx_q         <= idx_d;
            scnt_q        <= scnt_d;
            tcnt_q        <= tcnt_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_phase_q   <= res_phase_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_idx     = res_idx_q;
    assign res_phase   = res_phase_q;
    assign res_timeout = res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_onn_phase_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_onn_phase_scan_ctrl
//  Description : Scoreboard bench for onn_phase_scan_ctrl (N_OSC=4,
//                TIMEOUT=64). Stimulus pushes expected results; a monitor
//                pops and compares whenever res_valid is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onn_phase_scan_ctrl;
    import onn_pkg::*;

    localparam int N_OSC      = 4;
    localparam int IDX_W      = 4;
    localparam int CNT_W      = 16;
    localparam int SETTLE_CYC = 4;
    localparam int TIMEOUT    = 64;
    // Handshake -> next result when the next target times out
    localparam int TO_GAP     = 1 + SETTLE_CYC + TIMEOUT;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [IDX_W-1:0]        ref_sel;
    logic [N_OSC-1:0]        osc_in;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready;
    logic [IDX_W-1:0]        res_idx;
    logic signed [CNT_W-1:0] res_phase;
    logic                    res_timeout;
    logic                    done;

    typedef struct {
        int idx;
        int phase;
        int to;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   in_pres  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ncyc     = 0;
    int   last_hs  = 0;
    int   base     = 0;
    int   mode     = 0;
    int   off[N_OSC] = '{0, 5, 0, 12};

    onn_phase_scan_ctrl #(
        .N_OSC      (N_OSC),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ref_sel     (ref_sel),
        .osc_in      (osc_in),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_idx     (res_idx),
        .res_phase   (res_phase),
        .res_timeout (res_timeout),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int p, input int t, input int g);
        exp_t e;
        e.idx = i; e.phase = p; e.to = t; e.gap = g;
        exp_q.push_back(e);
    endtask

    // mode 0: period-20 oscillators rising at off[k], high 3 cycles
    // mode 1: ref pulses at pa and pa+10, osc1 at pa+15, osc2/osc3 silent
    function automatic logic [N_OSC-1:0] pattern(input int c);
        logic [N_OSC-1:0] o;
        int pa;
        o  = '0;
        pa = base + 21;
        if (mode == 0) begin
            for (int k = 0; k < N_OSC; k++)
                if (((((c - off[k]) % 20) + 20) % 20) < 3) o[k] = 1'b1;
        end else begin
            if ((c >= pa && c < pa + 3) || (c >= pa + 10 && c < pa + 13)) o[0] = 1'b1;
            if (c >= pa + 15 && c < pa + 18) o[1] = 1'b1;
        end
        return o;
    endfunction

    // Oscillator generator, updated just after each active edge
    initial begin
        osc_in = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            osc_in = pattern(cyc);
        end
    end

    // Monitor: pop on each new presentation, check hold while stalled
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset) begin
                in_pres = 1'b0;
            end else if (res_valid) begin
                if (!in_pres) begin
                    in_pres = 1'b1;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_result: got idx %0d phase %0d, expected none", res_idx, res_phase);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        chk("res_idx", res_idx, cur.idx);
                        chk("res_phase", res_phase, cur.phase);
                        chk("res_timeout", res_timeout, cur.to);
                        if (cur.gap >= 0) chk("result_gap", ncyc - last_hs, cur.gap);
                    end
                end else if (have_cur) begin
                    chk("hold_idx", res_idx, cur.idx);
                    chk("hold_phase", res_phase, cur.phase);
                    chk("hold_timeout", res_timeout, cur.to);
                end
                if (res_ready) begin
                    in_pres = 1'b0;
                    last_hs = ncyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start(input int sel);
        @(negedge clk);
        start   = 1'b1;
        ref_sel = IDX_W'(sel);
        base    = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, ok, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_valid"}, res_valid, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_idx"}, res_idx, 0);
        chk({name, "_phase"}, res_phase, 0);
        chk({name, "_timeout"}, res_timeout, 0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        bit ok;
        reset     = 1'b1;
        start     = 1'b0;
        ref_sel   = '0;
        res_ready = 1'b1;
        tick(3);
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        // Periodic pattern, out-of-range ref, extra starts while busy / at done
        mode = 0;
        off  = '{0, 5, 0, 12};
        push(0, 0, 0, -1);
        push(1, 5, 0, -1);
        push(2, 0, 0, -1);
        push(3, 12, 0, -1);
        do_start(9);
        chk("busy_after_start", busy, 1);
        tick(15);
        start   = 1'b1;
        ref_sel = IDX_W'(1);
        tick(1);
        start   = 1'b0;
        wait_done("scan_a");
        start   = 1'b1;
        ref_sel = IDX_W'(1);
        tick(1);
        start   = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        tick(6);
        chk("start_at_done_ignored_busy", busy, 0);
        chk("start_at_done_ignored_valid", res_valid, 0);
        chk("scan_a_queue_empty", exp_q.size(), 0);

        // Extra reference edge, backpressure on idx1, timeouts on idx2/idx3
        mode = 1;
        push(0, 0, 0, -1);
        push(1, 15, 0, -1);
        push(2, 0, 1, TO_GAP);
        push(3, 0, 1, TO_GAP);
        do_start(0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (res_valid && res_idx == IDX_W'(1)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_idx1_seen", ok, 1);
        res_ready = 1'b0;
        tick(20);
        res_ready = 1'b1;
        wait_done("scan_b");
        tick(1);
        chk("scan_b_busy_low", busy, 0);
        chk("scan_b_queue_empty", exp_q.size(), 0);

        // Reset while counting for idx2, then a clean rescan
        mode = 0;
        off  = '{0, 5, 10, 12};
        push(0, 0, 0, -1);
        push(1, 5, 0, -1);
        push(2, 10, 0, -1);
        push(3, 12, 0, -1);
        do_start(0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (dut.state_q == ST_COUNT && dut.idx_q == IDX_W'(2)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_count_idx2", ok, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midscan_reset");
        exp_q.delete();
        tick(2);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        chk("after_reset_busy", busy, 0);
        push(0, 0, 0, -1);
        push(1, 5, 0, -1);
        push(2, 10, 0, -1);
        push(3, 12, 0, -1);
        do_start(0);
        wait_done("scan_c");
        tick(1);
        chk("scan_c_busy_low", busy, 0);
        chk("scan_c_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
